// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: states, instruction
// fields, ALU operation codes and PC-mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    INS_NONE, INS_R, INS_ADDI, INS_LW, INS_SW, INS_BEQ, INS_J, INS_HALT
  } instr_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_SLT = 6'd4;

  localparam logic [1:0] PCSEL_INC = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;

  typedef struct packed {
    instr_e     kind;
    logic [5:0] alu;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder: opcode/funct -> instruction kind,
// ALU operation and legality.
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o.kind  = INS_NONE;
    dec_o.alu   = ALU_ADD;
    dec_o.legal = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        dec_o.kind = INS_R;
        case (funct_i)
          FN_ADD:  dec_o.alu = ALU_ADD;
          FN_SUB:  dec_o.alu = ALU_SUB;
          FN_AND:  dec_o.alu = ALU_AND;
          FN_OR:   dec_o.alu = ALU_OR;
          FN_SLT:  dec_o.alu = ALU_SLT;
          default: dec_o.legal = 1'b0;
        endcase
      end
      OP_ADDI: dec_o.kind = INS_ADDI;
      OP_LW:   dec_o.kind = INS_LW;
      OP_SW:   dec_o.kind = INS_SW;
      OP_BEQ: begin
        dec_o.kind = INS_BEQ;
        dec_o.alu  = ALU_SUB;
      end
      OP_J:    dec_o.kind = INS_J;
      OP_HALT: dec_o.kind = INS_HALT;
      default: dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB/PC and pulses the datapath write enables once.
module control_unit_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] out_alu,
  output logic             is_load_PC,
  output logic             is_write_reg,
  output logic             is_write_mem,
  output logic [5:0]       opcode_alu,
  output logic             is_R_type,
  output logic             is_I_type,
  output logic             is_J_type,
  output logic             is_write_from_mem,
  output logic [1:0]       control_mux_for_PC,
  output logic             halted,
  output logic             illegal,
  output logic [WIDTH-1:0] retired_count
);

  state_e           state_q, state_d;
  instr_e           kind_q, kind_d;
  logic [5:0]       alu_q, alu_d;
  logic             take_q, take_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] retired_q, retired_d;
  dec_t             dec;

  ctrl_decoder u_dec (
    .opcode_i (opcode),
    .funct_i  (funct),
    .dec_o    (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kind_q    <= INS_NONE;
      alu_q     <= ALU_ADD;
      take_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      alu_q     <= alu_d;
      take_q    <= take_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    kind_d             = kind_q;
    alu_d              = alu_q;
    take_d             = take_q;
    illegal_d          = illegal_q;
    retired_d          = retired_q;
    is_load_PC         = 1'b0;
    is_write_reg       = 1'b0;
    is_write_mem       = 1'b0;
    control_mux_for_PC = PCSEL_INC;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        kind_d = dec.kind;
        alu_d  = dec.alu;
        take_d = 1'b0;
        if (!dec.legal) begin
          // Illegal instructions leave no class/ALU state behind.
          illegal_d = 1'b1;
          kind_d    = INS_NONE;
          alu_d     = ALU_ADD;
          state_d   = S_HALT;
        end else if (dec.kind == INS_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (kind_q == INS_BEQ) take_d = (out_alu == '0);
        case (kind_q)
          INS_LW, INS_SW:  state_d = S_MEM;
          INS_R, INS_ADDI: state_d = S_WB;
          default:         state_d = S_PC;
        endcase
      end
      S_MEM: begin
        if (kind_q == INS_SW) begin
          is_write_mem = 1'b1;
          state_d      = S_PC;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        is_write_reg = 1'b1;
        state_d      = S_PC;
      end
      S_PC: begin
        is_load_PC = 1'b1;
        if (kind_q == INS_J)                control_mux_for_PC = PCSEL_JMP;
        else if (kind_q == INS_BEQ && take_q) control_mux_for_PC = PCSEL_BR;
        retired_d = retired_q + WIDTH'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // A reset arriving mid-instruction must suppress the pulse of that cycle.
    if (rst) begin
      is_load_PC         = 1'b0;
      is_write_reg       = 1'b0;
      is_write_mem       = 1'b0;
      control_mux_for_PC = PCSEL_INC;
    end
  end

  assign opcode_alu        = alu_q;
  assign is_R_type         = (kind_q == INS_R);
  assign is_I_type         = (kind_q == INS_ADDI) || (kind_q == INS_LW) || (kind_q == INS_SW);
  assign is_J_type         = (kind_q == INS_J);
  assign is_write_from_mem = (kind_q == INS_LW);
  assign halted            = (state_q == S_HALT);
  assign illegal           = illegal_q;
  assign retired_count     = retired_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed and random instruction
// streams compared against a cycle-schedule model of each instruction.
module tb_control_unit_fsm;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, run;
  logic [5:0]       opcode, funct;
  logic [WIDTH-1:0] out_alu;
  logic             is_load_PC, is_write_reg, is_write_mem;
  logic [5:0]       opcode_alu;
  logic             is_R_type, is_I_type, is_J_type, is_write_from_mem;
  logic [1:0]       control_mux_for_PC;
  logic             halted, illegal;
  logic [WIDTH-1:0] retired_count;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  control_unit_fsm #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .out_alu(out_alu), .is_load_PC(is_load_PC), .is_write_reg(is_write_reg),
    .is_write_mem(is_write_mem), .opcode_alu(opcode_alu), .is_R_type(is_R_type),
    .is_I_type(is_I_type), .is_J_type(is_J_type),
    .is_write_from_mem(is_write_from_mem),
    .control_mux_for_PC(control_mux_for_PC), .halted(halted),
    .illegal(illegal), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wreg"}, 64'(is_write_reg), 64'(0));
    chk({tag, "_wmem"}, 64'(is_write_mem), 64'(0));
    chk({tag, "_load"}, 64'(is_load_PC), 64'(0));
  endtask

  // One instruction starting in its FETCH cycle (called just after a posedge).
  // The expected schedule comes from the per-class latency rules.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input logic [WIDTH-1:0] exec_alu,
                          input int run_low_at, input int abort_at);
    int lat, wr_c, wm_c, e_r, e_i, e_j, e_alu, e_wfm, e_mux;
    bit aborted;
    lat = 5; wr_c = 0; wm_c = 0; e_r = 0; e_i = 0; e_j = 0;
    e_alu = 0; e_wfm = 0; e_mux = 0; aborted = 1'b0;
    case (op)
      6'h00: begin
        wr_c = 4; e_r = 1;
        case (fn)
          6'h20: e_alu = 0;
          6'h22: e_alu = 1;
          6'h24: e_alu = 2;
          6'h25: e_alu = 3;
          default: e_alu = 4;
        endcase
      end
      6'h08: begin wr_c = 4; e_i = 1; end
      6'h23: begin lat = 6; wr_c = 5; e_i = 1; e_wfm = 1; end
      6'h2B: begin wm_c = 4; e_i = 1; end
      6'h04: begin lat = 4; e_alu = 1; e_mux = (exec_alu == 0) ? 1 : 0; end
      default: begin lat = 4; e_j = 1; e_mux = 2; end
    endcase
    for (int c = 1; c <= lat; c++) begin
      opcode  = op;
      funct   = fn;
      out_alu = (c == 3) ? exec_alu : WIDTH'($urandom);
      if (c == run_low_at) run = 1'b0;
      if (c == abort_at) begin rst = 1'b1; aborted = 1'b1; end
      @(negedge clk);
      chk("wreg", 64'(is_write_reg), 64'(!aborted && c == wr_c));
      chk("wmem", 64'(is_write_mem), 64'(!aborted && c == wm_c));
      chk("load", 64'(is_load_PC), 64'(!aborted && c == lat));
      chk("retired", 64'(retired_count), 64'(WIDTH'(exp_ret)));
      chk("halted", 64'(halted), 64'(0));
      chk("illegal", 64'(illegal), 64'(0));
      if (c == lat && !aborted) chk("pcmux", 64'(control_mux_for_PC), 64'(e_mux));
      if (c >= 3) begin
        chk("isR", 64'(is_R_type), 64'(e_r));
        chk("isI", 64'(is_I_type), 64'(e_i));
        chk("isJ", 64'(is_J_type), 64'(e_j));
        chk("aluop", 64'(opcode_alu), 64'(e_alu));
        chk("wfm", 64'(is_write_from_mem), 64'(e_wfm));
      end
      @(posedge clk); #1;
      if (aborted) break;
    end
    if (!aborted) exp_ret++;
  endtask

  // HALT or illegal instruction: absorbing until reset.
  task automatic do_stop(input logic [5:0] op, input logic [5:0] fn, input bit exp_ill);
    for (int c = 1; c <= 2; c++) begin
      opcode = op; funct = fn;
      @(negedge clk);
      chk_quiet("stop_pre");
      chk("stop_pre_halted", 64'(halted), 64'(0));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 20; k++) begin
      run    = 1'($urandom);
      opcode = 6'($urandom);
      @(negedge clk);
      chk_quiet("halt");
      chk("halt_halted", 64'(halted), 64'(1));
      chk("halt_illegal", 64'(illegal), 64'(exp_ill));
      chk("halt_retired", 64'(retired_count), 64'(WIDTH'(exp_ret)));
      @(posedge clk); #1;
    end
    run = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    chk("stop_rst_halted", 64'(halted), 64'(0));
    chk("stop_rst_illegal", 64'(illegal), 64'(0));
    chk("stop_rst_retired", 64'(retired_count), 64'(0));
  endtask

  task automatic start_run();
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_hold(input string tag, input int n);
    opcode = 6'h00; funct = 6'h20;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_quiet(tag);
      chk({tag, "_retired"}, 64'(retired_count), 64'(WIDTH'(exp_ret)));
      chk({tag, "_halted"}, 64'(halted), 64'(0));
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    logic [WIDTH-1:0] av;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    rst = 1'b1; run = 1'b0; opcode = 6'h00; funct = 6'h20; out_alu = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_aluop", 64'(opcode_alu), 64'(0));
    chk("rst_flags", 64'({is_R_type, is_I_type, is_J_type, is_write_from_mem}), 64'(0));
    chk("rst_mux", 64'(control_mux_for_PC), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_retired", 64'(retired_count), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    start_run();

    // Directed instruction mix
    do_instr(6'h00, 6'h20, WIDTH'(7), 0, 0);
    do_instr(6'h23, 6'h00, WIDTH'(3), 0, 0);
    do_instr(6'h2B, 6'h11, WIDTH'(9), 0, 0);
    do_instr(6'h04, 6'h00, WIDTH'(0), 0, 0);
    do_instr(6'h04, 6'h00, WIDTH'(5), 0, 0);
    do_instr(6'h02, 6'h3F, WIDTH'(0), 0, 0);

    // Random legal program
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 5)];
      fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      av = ($urandom_range(0, 1) == 1) ? '0 : WIDTH'($urandom_range(1, 100000));
      do_instr(op, fn, av, 0, 0);
    end

    // run dropped during EXEC: instruction completes, then parks
    do_instr(6'h00, 6'h22, WIDTH'(1), 3, 0);
    idle_hold("park", 6);
    start_run();
    do_instr(6'h08, 6'h00, WIDTH'(1), 0, 0);

    // reset during WB of an ADD
    do_instr(6'h00, 6'h20, WIDTH'(1), 0, 4);
    rst = 1'b0; run = 1'b0; exp_ret = 0;
    @(negedge clk);
    chk("abort_flags", 64'({is_R_type, is_I_type, is_J_type, is_write_from_mem}), 64'(0));
    idle_hold("abort", 4);
    start_run();
    do_instr(6'h00, 6'h25, WIDTH'(2), 0, 0);

    // Illegal opcode, HALT, illegal funct
    do_stop(6'h11, 6'h20, 1'b1);
    start_run();
    do_stop(6'h3F, 6'h00, 1'b0);
    start_run();
    do_stop(6'h00, 6'h21, 1'b1);
    start_run();
    do_instr(6'h02, 6'h00, WIDTH'(0), 0, 0);
    do_instr(6'h2B, 6'h00, WIDTH'(0), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
